// File: rtl/word_aligner.sv
`timescale 1ns/1ps
// word_aligner
//   Comma-based word aligner that sits right after the deserializer. Incoming
//   10-bit words have arbitrary bit phase. Each new word is joined with the
//   previous one to form a 20-bit window. The ten possible 10-bit alignments
//   are searched for a K28.5 comma of either disparity. Repeated commas at one
//   offset lock the aligner to that offset. While locked, words are re-framed
//   on true symbol boundaries. Repeated commas at another offset drop the lock.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   datin        unaligned input word, bit 0 = earliest received bit
//   datin_valid  strobe: datin carries a new word this cycle
//   datout       aligned output word, bit 0 = symbol bit a
//   dout_valid   strobe: datout carries a new aligned word this cycle
//   aligned      high while locked
//   comma_det    high when the current datout is a K28.5
//   align_offset current candidate or locked bit offset (0-9)
module word_aligner #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] datin,
  input  logic       datin_valid,
  output logic [9:0] datout,
  output logic       dout_valid,
  output logic       aligned,
  output logic       comma_det,
  output logic [3:0] align_offset
);

  localparam logic [9:0] K_NEG     = 10'h17C;
  localparam logic [9:0] K_POS     = 10'h283;
  localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  offset, offset_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  miss, miss_nxt;
  logic [9:0]  prev;
  logic        prev_full;

  logic [19:0] window;
  logic [9:0]  hit;
  logic        found;
  logic [3:0]  fk;
  logic [9:0]  cand_sel;
  logic        hit_sel;
  logic        advance;
  logic [3:0]  cnt_inc;
  logic [3:0]  miss_inc;

  // Older word in the low half, so candidate k starts k bits into the older word.
  assign window   = {datin, prev};
  assign found    = |hit;
  assign advance  = datin_valid && prev_full;
  assign cnt_inc  = cnt + 4'd1;
  assign miss_inc = miss + 4'd1;

  // Comma search over all ten candidates. It is disabled until a previous word exists.
  // NOTE: every always_comb output gets a default first so that no path leaves it unassigned (no latch).
  always_comb begin
    hit = '0;
    for (int k = 0; k < 10; k++) begin
      if (prev_full && (window[k +: 10] == K_NEG || window[k +: 10] == K_POS)) begin
        hit[k] = 1'b1;
      end
    end
  end

  // Priority pick of the lowest hitting offset. Scanning downward lets the lowest hit win.
  always_comb begin
    fk = '0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) fk = 4'(k);
    end
  end

  // Candidate and hit flag at the current offset. A mux is used instead of a
  // variable part-select so that offset values 10-15 cannot index past the window.
  always_comb begin
    cand_sel = '0;
    hit_sel  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (offset == 4'(k)) begin
        cand_sel = window[k +: 10];
        hit_sel  = hit[k];
      end
    end
  end

  // Next-state logic. A word with no comma anywhere leaves everything untouched.
  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    cnt_nxt    = cnt;
    miss_nxt   = miss;
    if (advance && found) begin
      unique case (state)
        HUNT: begin
          offset_nxt = fk;
          cnt_nxt    = 4'd1;
          if (LOCK_TH == 4'd1) begin
            state_nxt = LOCKED;
            miss_nxt  = '0;
          end else begin
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (hit_sel) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == LOCK_TH) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            // Comma seen elsewhere: restart the count at the new offset.
            offset_nxt = fk;
            cnt_nxt    = 4'd1;
          end
        end
        LOCKED: begin
          if (hit_sel) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = miss_inc;
            if (miss_inc == UNLOCK_TH) begin
              // Drop back to HUNT. The offset is kept for observability.
              state_nxt = HUNT;
              cnt_nxt   = '0;
              miss_nxt  = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers (prev, datout) are reset as well, because the reset state defines them as zero.
    if (reset) begin
      state        <= HUNT;
      offset       <= '0;
      cnt          <= '0;
      miss         <= '0;
      prev         <= '0;
      prev_full    <= 1'b0;
      datout       <= '0;
      dout_valid   <= 1'b0;
      comma_det    <= 1'b0;
      aligned      <= 1'b0;
      align_offset <= '0;
    end else begin
      state  <= state_nxt;
      offset <= offset_nxt;
      cnt    <= cnt_nxt;
      miss   <= miss_nxt;
      if (datin_valid) begin
        prev      <= datin;
        prev_full <= 1'b1;
      end
      // Output uses the state before the edge. The word that causes lock entry
      // is therefore not emitted, and the word that causes lock exit still is.
      dout_valid <= datin_valid && (state == LOCKED);
      if (datin_valid && (state == LOCKED)) begin
        datout    <= cand_sel;
        comma_det <= hit_sel;
      end
      aligned      <= (state_nxt == LOCKED);
      align_offset <= offset_nxt;
    end
  end

endmodule

// File: tb/tb_word_aligner.sv
`timescale 1ns/1ps
module tb_word_aligner;

  localparam logic [9:0] K_NEG  = 10'h17C;
  localparam logic [9:0] K_POS  = 10'h283;
  localparam int         LOCK   = 3;
  localparam int         UNLOCK = 2;

  logic       clk;
  logic       reset;
  logic [9:0] datin;
  logic       datin_valid;
  logic [9:0] datout;
  logic       dout_valid;
  logic       aligned;
  logic       comma_det;
  logic [3:0] align_offset;

  int total = 0;
  int bad   = 0;

  word_aligner #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
    .clk          (clk),
    .reset        (reset),
    .datin        (datin),
    .datin_valid  (datin_valid),
    .datout       (datout),
    .dout_valid   (dout_valid),
    .aligned      (aligned),
    .comma_det    (comma_det),
    .align_offset (align_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the last word and a streak/miss tally. On every valid word
  // it slides the 20-bit window with shifts to find commas.
  bit         live = 1'b0;
  logic [9:0] m_prev;
  bit         m_pf;
  bit         m_locked;
  bit         m_counting;
  int         m_off, m_streak, m_miss;
  logic [9:0] e_dat;
  bit         e_dv, e_cd, e_al;
  logic [3:0] e_off;

  always @(posedge clk) begin : model
    logic [19:0] w;
    bit   [9:0]  h;
    int          first;
    if (reset) begin
      live = 1'b1;
      m_prev = '0; m_pf = 0; m_locked = 0; m_counting = 0;
      m_off = 0; m_streak = 0; m_miss = 0;
      e_dat = '0; e_dv = 0; e_cd = 0; e_al = 0; e_off = '0;
    end else if (datin_valid) begin
      w = {datin, m_prev};
      h = '0;
      first = -1;
      for (int k = 0; k < 10; k++) begin
        if (m_pf && ((10'(w >> k) == K_NEG) || (10'(w >> k) == K_POS))) begin
          h[k] = 1'b1;
          if (first < 0) first = k;
        end
      end
      e_dv = m_locked;
      if (m_locked) begin
        e_dat = 10'(w >> m_off);
        e_cd  = h[m_off];
      end
      if (first >= 0) begin
        if (m_locked) begin
          m_miss = h[m_off] ? 0 : m_miss + 1;
          if (m_miss == UNLOCK) begin
            m_locked = 0; m_counting = 0; m_streak = 0; m_miss = 0;
          end
        end else begin
          if (m_counting && h[m_off]) m_streak++;
          else begin m_off = first; m_streak = 1; end
          m_counting = 1;
          if (m_streak == LOCK) begin m_locked = 1; m_miss = 0; end
        end
      end
      m_prev = datin;
      m_pf   = 1;
      e_al   = m_locked;
      e_off  = 4'(m_off);
    end else begin
      e_dv = 0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("dout_valid",   10'(dout_valid),   10'(e_dv));
      check("datout",       datout,            e_dat);
      check("comma_det",    10'(comma_det),    10'(e_cd));
      check("aligned",      10'(aligned),      10'(e_al));
      check("align_offset", 10'(align_offset), 10'(e_off));
    end
  end

  // ---------------- stimulus helpers ----------------
  bit bq[$];

  task automatic cyc(input logic v, input logic [9:0] w, input logic r);
    @(posedge clk);
    #1;
    datin_valid = v;
    datin       = w;
    reset       = r;
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
  endtask

  task automatic push_fill(input int n, input bit rnd);
    for (int i = 0; i < n; i++) bq.push_back(rnd ? 1'($urandom) : 1'b0);
  endtask

  // Pop up to n words from the bit queue, with gap idle cycles after each word.
  task automatic send_q(input int n, input int gap);
    logic [9:0] w;
    for (int i = 0; i < n && bq.size() >= 10; i++) begin
      for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
      cyc(1'b1, w, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 10'($urandom), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    datin_valid = 1'b0;
    datin = '0;
    do_reset();

    // Reset state
    check("rst aligned", 10'(aligned), 10'd0);
    check("rst dout_valid", 10'(dout_valid), 10'd0);
    check("rst datout", datout, 10'h000);
    check("rst offset", 10'(align_offset), 10'd0);

    // RD- commas delayed 3 bits
    repeat (4) cyc(1'b1, 10'h3E2, 1'b0);
    cyc(1'b1, 10'h3E2, 1'b0);
    check("off3 aligned", 10'(aligned), 10'd1);
    check("off3 offset", 10'(align_offset), 10'd3);
    check("off3 lock word hidden", 10'(dout_valid), 10'd0);
    cyc(1'b0, '0, 1'b0);
    check("off3 dout_valid", 10'(dout_valid), 10'd1);
    check("off3 datout", datout, 10'h17C);
    check("off3 comma_det", 10'(comma_det), 10'd1);

    // Shift the same stream to offset 7 while locked
    bq.delete();
    push_fill(7, 1'b0);
    repeat (8) push_sym(K_NEG);
    send_q(2, 0);
    cyc(1'b0, '0, 1'b0);
    check("shift miss1 aligned", 10'(aligned), 10'd1);
    check("shift miss1 datout", datout, 10'h3C0);
    send_q(1, 0);
    cyc(1'b0, '0, 1'b0);
    check("shift miss2 aligned", 10'(aligned), 10'd0);
    check("shift exit word out", 10'(dout_valid), 10'd1);
    send_q(3, 0);
    cyc(1'b0, '0, 1'b0);
    check("relock aligned", 10'(aligned), 10'd1);
    check("relock offset", 10'(align_offset), 10'd7);

    // Zero-offset stream with idle gaps
    do_reset();
    repeat (4) cyc(1'b1, K_NEG, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, K_NEG, 1'b0);
      for (int j = 0; j < 5; j++) begin
        cyc(1'b0, 10'($urandom), 1'b0);
        check("idle datout", datout, 10'h17C);
        check("idle aligned", 10'(aligned), 10'd1);
        check("idle dout_valid", 10'(dout_valid), (j == 0) ? 10'd1 : 10'd0);
      end
    end

    // Reset while locked with a valid word present
    cyc(1'b1, K_NEG, 1'b1);
    cyc(1'b0, '0, 1'b0);
    check("midrst aligned", 10'(aligned), 10'd0);
    check("midrst dout_valid", 10'(dout_valid), 10'd0);
    check("midrst datout", datout, 10'h000);
    check("midrst offset", 10'(align_offset), 10'd0);
    repeat (3) cyc(1'b1, K_NEG, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("midrst not yet", 10'(aligned), 10'd0);
    cyc(1'b1, K_NEG, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("midrst relock", 10'(aligned), 10'd1);

    // The first word after reset is never searched. A search on 0BE would report offset 9.
    do_reset();
    cyc(1'b1, 10'h0BE, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("first word ignored", 10'(align_offset), 10'd0);
    do_reset();
    cyc(1'b1, 10'h000, 1'b0);
    cyc(1'b1, K_NEG, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("second word offset", 10'(align_offset), 10'd0);
    check("second word aligned", 10'(aligned), 10'd0);

    // VERIFY with cnt=2 at offset 3, then a comma at offset 5
    do_reset();
    repeat (3) cyc(1'b1, 10'h3E2, 1'b0);
    bq.delete();
    push_fill(5, 1'b0);
    repeat (6) push_sym(K_NEG);
    send_q(2, 0);
    cyc(1'b0, '0, 1'b0);
    check("restart offset", 10'(align_offset), 10'd5);
    check("restart aligned", 10'(aligned), 10'd0);
    send_q(1, 0);
    cyc(1'b0, '0, 1'b0);
    check("restart cnt2", 10'(aligned), 10'd0);
    send_q(1, 0);
    cyc(1'b0, '0, 1'b0);
    check("restart lock", 10'(aligned), 10'd1);
    check("restart lock off", 10'(align_offset), 10'd5);

    // Randomized streams: random phase slips, comma/data mix, idles, resets
    bq.delete();
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      push_fill($urandom_range(0, 9), 1'b1);
      for (int i = 0, n = $urandom_range(6, 30); i < n; i++) begin
        if ($urandom_range(0, 99) < 70) push_sym($urandom_range(0, 1) ? K_NEG : K_POS);
        else push_sym(10'($urandom));
      end
      while (bq.size() >= 10) send_q(1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    repeat (3) cyc(1'b0, '0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
